// File: rtl/i2c_master_byte_seq.sv
`default_nettype none
// ============================================================================
// i2c_master_byte_seq -- byte-level I2C command sequencer for a bit controller
// Revision: 1.0
// ============================================================================
module i2c_master_byte_seq (
  input  logic       clk,
  input  logic       nReset,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       i2c_al,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd,
  input  logic       core_al
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cmd_nxt;
  logic       txd_nxt;
  logic       cmd_ack_nxt;
  logic       ack_out_nxt;
  logic [7:0] sr, sr_nxt;
  logic [2:0] bcnt, bcnt_nxt;

  logic       go;
  logic       last_bit;
  logic [7:0] sr_shift;
  logic [2:0] bcnt_dec;

  assign go       = (read | write | stop) & ~cmd_ack;
  assign last_bit = (bcnt == 3'd0);
  assign sr_shift = {sr[6:0], core_rxd};
  // Saturating decrement so the counter can never wrap past the last bit
  assign bcnt_dec = last_bit ? 3'd0 : (bcnt - 3'd1);
  assign dout     = sr;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= ST_IDLE;
      core_cmd <= CMD_NOP;
      core_txd <= 1'b0;
      cmd_ack  <= 1'b0;
      ack_out  <= 1'b0;
      i2c_al   <= 1'b0;
      sr       <= 8'h00;
      bcnt     <= 3'd0;
    end else if (rst) begin
      state    <= ST_IDLE;
      core_cmd <= CMD_NOP;
      core_txd <= 1'b0;
      cmd_ack  <= 1'b0;
      ack_out  <= 1'b0;
      i2c_al   <= 1'b0;
      sr       <= 8'h00;
      bcnt     <= 3'd0;
    end else begin
      state    <= state_nxt;
      core_cmd <= cmd_nxt;
      core_txd <= txd_nxt;
      cmd_ack  <= cmd_ack_nxt;
      ack_out  <= ack_out_nxt;
      i2c_al   <= core_al;
      sr       <= sr_nxt;
      bcnt     <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_nxt     = core_cmd;
    txd_nxt     = core_txd;
    cmd_ack_nxt = 1'b0;
    ack_out_nxt = ack_out;
    sr_nxt      = sr;
    bcnt_nxt    = bcnt;

    if (core_al) begin
      // Lost arbitration: drop everything and release the bus
      state_nxt   = ST_IDLE;
      cmd_nxt     = CMD_NOP;
      txd_nxt     = 1'b0;
      ack_out_nxt = 1'b0;
      sr_nxt      = 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            sr_nxt   = din;
            bcnt_nxt = 3'd7;
            if (start) begin
              state_nxt = ST_START;
              cmd_nxt   = CMD_START;
            end else if (read) begin
              state_nxt = ST_READ;
              cmd_nxt   = CMD_READ;
            end else if (write) begin
              state_nxt = ST_WRITE;
              cmd_nxt   = CMD_WRITE;
              txd_nxt   = din[7];
            end else begin
              state_nxt = ST_STOP;
              cmd_nxt   = CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (core_ack) begin
            sr_nxt   = din;
            bcnt_nxt = 3'd7;
            if (read) begin
              state_nxt = ST_READ;
              cmd_nxt   = CMD_READ;
            end else begin
              state_nxt = ST_WRITE;
              cmd_nxt   = CMD_WRITE;
              txd_nxt   = din[7];
            end
          end
        end

        ST_WRITE: begin
          if (core_ack) begin
            sr_nxt   = sr_shift;
            bcnt_nxt = bcnt_dec;
            if (last_bit) begin
              state_nxt = ST_ACK;
              cmd_nxt   = CMD_READ;
            end else begin
              txd_nxt = sr[6];
            end
          end
        end

        ST_READ: begin
          if (core_ack) begin
            sr_nxt   = sr_shift;
            bcnt_nxt = bcnt_dec;
            if (last_bit) begin
              state_nxt = ST_ACK;
              cmd_nxt   = CMD_WRITE;
              txd_nxt   = ack_in;
            end
          end
        end

        ST_ACK: begin
          if (core_ack) begin
            ack_out_nxt = core_rxd;
            txd_nxt     = 1'b1;
            if (stop) begin
              state_nxt = ST_STOP;
              cmd_nxt   = CMD_STOP;
            end else begin
              state_nxt   = ST_IDLE;
              cmd_nxt     = CMD_NOP;
              cmd_ack_nxt = 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (core_ack) begin
            state_nxt   = ST_IDLE;
            cmd_nxt     = CMD_NOP;
            cmd_ack_nxt = 1'b1;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
          cmd_nxt   = CMD_NOP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_byte_seq.sv
`default_nettype none
// ============================================================================
// tb_i2c_master_byte_seq -- randomized scoreboard bench with a bit-controller model
// Revision: 1.0
// ============================================================================
module tb_i2c_master_byte_seq;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] STA = 4'b0001;
  localparam logic [3:0] STO = 4'b0010;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] RD  = 4'b1000;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0, ack_in = 1'b0;
  logic [7:0] din = 8'h00;
  logic       cmd_ack, ack_out, i2c_al, core_txd;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic       core_ack = 1'b0, core_rxd = 1'b0, core_al = 1'b0;

  i2c_master_byte_seq dut (
    .clk(clk), .nReset(nReset), .rst(rst),
    .start(start), .stop(stop), .read(read), .write(write), .ack_in(ack_in),
    .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout), .i2c_al(i2c_al),
    .core_cmd(core_cmd), .core_txd(core_txd), .core_ack(core_ack),
    .core_rxd(core_rxd), .core_al(core_al)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cmd;
    logic       chk;
    logic       txd;
    logic       rxd;
  } bit_t;

  typedef struct {
    logic       ack;
    logic [7:0] dout;
  } res_t;

  bit_t exp_bits[$];
  res_t exp_res[$];
  bit_t bm_b;
  res_t mon_r;
  int   tests = 0;
  int   fails = 0;
  logic bc_en = 1'b0;
  logic model_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_bit(input logic [3:0] c, input logic ck, input logic t, input logic r);
    bit_t b;
    b.cmd = c; b.chk = ck; b.txd = t; b.rxd = r;
    exp_bits.push_back(b);
  endfunction

  // Reference: bus echoes driven bits, read bits come from rb, slave ack from sa
  task automatic expect_txn(input logic st, input logic sp, input logic rd, input logic wr,
                            input logic [7:0] d, input logic ai, input logic [7:0] rb,
                            input logic sa);
    res_t r;
    if (st) push_bit(STA, 1'b0, 1'b0, 1'b0);
    if (rd) begin
      for (int i = 7; i >= 0; i--) push_bit(RD, 1'b0, 1'b0, rb[i]);
      push_bit(WR, 1'b1, ai, ai);
      model_ack = ai;
      r.dout = rb;
    end else if (wr) begin
      for (int i = 7; i >= 0; i--) push_bit(WR, 1'b1, d[i], d[i]);
      push_bit(RD, 1'b0, 1'b0, sa);
      model_ack = sa;
      r.dout = d;
    end else begin
      r.dout = d;
    end
    if (sp) push_bit(STO, 1'b0, 1'b0, 1'b0);
    r.ack = model_ack;
    exp_res.push_back(r);
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ack && n < 400);
    if (!cmd_ack) begin
      tests++;
      fails++;
      $display("FAIL %s: cmd_ack=0 after 400 cycles, expected 1", name);
    end
  endtask

  task automatic run_txn(input logic st, input logic sp, input logic rd, input logic wr,
                         input logic [7:0] d, input logic ai, input logic [7:0] rb,
                         input logic sa, input bit hold);
    expect_txn(st, sp, rd, wr, d, ai, rb, sa);
    @(negedge clk);
    start = st; stop = sp; read = rd; write = wr; din = d; ack_in = ai;
    wait_ack("txn_timeout");
    if (!hold) begin
      start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
    end
  endtask

  task automatic wait_cmd(input logic [3:0] c, input string name);
    int n = 0;
    while (core_cmd !== c && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, core_cmd, c);
  endtask

  task automatic man_ack(input logic rx);
    core_rxd = rx;
    core_ack = 1'b1;
    @(negedge clk);
    core_ack = 1'b0;
    @(negedge clk);
  endtask

  // Bit-controller model: acknowledges each command after a random latency
  initial begin
    forever begin
      @(negedge clk);
      if (bc_en && nReset && core_cmd != NOP) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (exp_bits.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bit_unexpected: core_cmd=0x%0h, expected no command", core_cmd);
          core_rxd = 1'b0;
        end else begin
          bm_b = exp_bits.pop_front();
          check("bit_cmd", core_cmd, bm_b.cmd);
          if (bm_b.chk) check("bit_txd", core_txd, bm_b.txd);
          core_rxd = bm_b.rxd;
        end
        core_ack = 1'b1;
        @(negedge clk);
        core_ack = 1'b0;
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (nReset && cmd_ack) begin
      if (exp_res.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL cmd_ack_unexpected: cmd_ack=1, expected 0 (t=%0t)", $time);
      end else begin
        mon_r = exp_res.pop_front();
        check("ack_out", ack_out, mon_r.ack);
        check("dout", dout, mon_r.dout);
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic st, sp, rd, wr;

    // Reset state
    #1;
    check("rst_cmd", core_cmd, NOP);
    check("rst_txd", core_txd, 1'b0);
    check("rst_cmd_ack", cmd_ack, 1'b0);
    check("rst_ack_out", ack_out, 1'b0);
    check("rst_al", i2c_al, 1'b0);
    check("rst_dout", dout, 8'h00);
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    bc_en = 1'b1;
    repeat (2) @(negedge clk);

    // start + write 0xA5, slave ACK 0
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
    // read with NACK and stop, bus returns 0x3C
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0);
    check("read_dout_hold", dout, 8'h3C);
    // stop alone
    run_txn(1'b0, 1'b1, 1'b0, 0, 8'h17, 1'b0, 8'h00, 1'b0, 1'b0);
    check("stop_cmd_nop", core_cmd, NOP);

    // write held across cmd_ack: one idle cycle, then a second byte
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 8'h6E, 1'b0, 8'h00, 1'b1, 1'b1);
    check("hold_cmd_ackcyc", core_cmd, NOP);
    expect_txn(1'b0, 1'b0, 1'b0, 1'b1, 8'h6E, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("hold_cmd_gap", core_cmd, NOP);
    @(negedge clk);
    check("hold_cmd_second", core_cmd, WR);
    wait_ack("hold_timeout");
    write = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      sp = 1'($urandom_range(0, 1));
      if (!rd && !wr) begin
        st = 1'b0;
        sp = 1'b1;
      end
      run_txn(st, sp, rd, wr, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Arbitration lost at the 4th written bit
    bc_en = 1'b0;
    d = 8'hC3;
    @(negedge clk);
    write = 1'b1; din = d;
    wait_cmd(WR, "al_cmd_write");
    for (int i = 0; i < 3; i++) begin
      check("al_txd", core_txd, d[7 - i]);
      man_ack(d[7 - i]);
    end
    check("al_txd4", core_txd, d[4]);
    write = 1'b0;
    core_al = 1'b1;
    @(negedge clk);
    core_al = 1'b0;
    check("al_cmd", core_cmd, NOP);
    check("al_flag", i2c_al, 1'b1);
    check("al_txd0", core_txd, 1'b0);
    check("al_dout", dout, 8'h00);
    check("al_ack_out", ack_out, 1'b0);
    check("al_cmd_ack", cmd_ack, 1'b0);
    model_ack = 1'b0;
    @(negedge clk);
    check("al_flag_clear", i2c_al, 1'b0);
    repeat (5) @(negedge clk);
    check("al_idle", core_cmd, NOP);

    // Asynchronous reset mid-read (bcnt = 3)
    read = 1'b1; din = 8'h5A;
    wait_cmd(RD, "nrst_cmd_read");
    for (int i = 0; i < 4; i++) man_ack(1'b1);
    #2;
    nReset = 1'b0;
    read = 1'b0;
    #1;
    check("nrst_cmd", core_cmd, NOP);
    check("nrst_dout", dout, 8'h00);
    check("nrst_cmd_ack", cmd_ack, 1'b0);
    @(negedge clk);
    nReset = 1'b1;
    model_ack = 1'b0;
    bc_en = 1'b1;
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);

    // Synchronous reset mid-write
    bc_en = 1'b0;
    @(negedge clk);
    write = 1'b1; din = 8'h81;
    wait_cmd(WR, "srst_cmd_write");
    man_ack(1'b1);
    man_ack(1'b0);
    rst = 1'b1;
    write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("srst_cmd", core_cmd, NOP);
    check("srst_dout", dout, 8'h00);
    check("srst_txd", core_txd, 1'b0);
    model_ack = 1'b0;
    bc_en = 1'b1;
    run_txn(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h96, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    check("bits_left", exp_bits.size(), 0);
    check("res_left", exp_res.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master_byte_seq.md
I2C_MASTER_BYTE_SEQ -- requirements
Module: i2c_master_byte_seq

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port: nReset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have host ports, all inputs of width 1: start, stop, read, write, ack_in. Each is level-sampled.
REQ-005 SHALL have port: din  input  8  byte to transmit.
REQ-006 SHALL have ports: cmd_ack  output  1  command done; ack_out  output  1  received ACK bit.
REQ-007 SHALL have ports: dout  output  8  received byte; i2c_al  output  1  arbitration lost (mirror of core_al).
REQ-008 SHALL have port: core_cmd  output  4  command to the bit controller.
REQ-009 SHALL have ports: core_txd  output  1  bit to drive; core_ack  input  1  bit-controller done pulse; core_rxd  input  1  sampled bit; core_al  input  1  arbitration lost.
REQ-010 SHALL use these core_cmd encodings: NOP 4'b0000, START 4'b0001, STOP 4'b0010, WRITE 4'b0100, READ 4'b1000.

Function
REQ-011 SHALL implement states IDLE, START, WRITE, READ, ACK, STOP, plus an 8-bit shift register sr and a 3-bit down-counter bcnt.
REQ-012 SHALL define go = (read | write | stop) & ~cmd_ack; in IDLE with go, it SHALL load sr <= din and bcnt <= 7.
REQ-013 SHALL use this priority in IDLE when go is true, first match wins:
  - start -> START, core_cmd = START
  - read -> READ, core_cmd = READ
  - write -> WRITE, core_cmd = WRITE
  - otherwise -> STOP, core_cmd = STOP
REQ-014 SHALL hold core_cmd stable from issue until the cycle core_ack = 1, and SHALL ignore core_ack outside the START, WRITE, READ, ACK and STOP states.
REQ-015 START on core_ack SHALL:
  - go to READ with core_cmd = READ if read = 1;
  - otherwise go to WRITE with core_cmd = WRITE;
  - reload sr <= din and bcnt <= 7.
REQ-016 WRITE SHALL drive core_txd = sr[7]. On core_ack it SHALL shift sr left with sr[0] <= core_rxd and decrement bcnt.
REQ-017 WRITE on core_ack with bcnt == 0 SHALL go to ACK with core_cmd = READ; otherwise it SHALL reissue WRITE.
REQ-018 READ on core_ack SHALL shift sr left with sr[0] <= core_rxd and decrement bcnt. With bcnt == 0 it SHALL go to ACK with core_cmd = WRITE and core_txd = ack_in; otherwise it SHALL reissue READ.
REQ-019 ACK on core_ack SHALL:
  - set ack_out <= core_rxd and core_txd <= 1;
  - if stop = 1, go to STOP with core_cmd = STOP;
  - otherwise go to IDLE with core_cmd = NOP and pulse cmd_ack.
REQ-020 STOP on core_ack SHALL go to IDLE with core_cmd = NOP and pulse cmd_ack.
REQ-021 cmd_ack SHALL be high for exactly 1 clk cycle per completed command. The host SHALL clear start/stop/read/write in that same cycle.
REQ-022 dout SHALL equal sr continuously; after a READ completes it SHALL hold the received byte, MSB first on the wire.
REQ-023 bcnt SHALL never wrap: exactly 8 data bits SHALL be transferred per byte, followed by 1 ACK bit.
REQ-024 core_al = 1 in any state SHALL, next cycle:
  - force IDLE;
  - set core_cmd = NOP, core_txd = 0, cmd_ack = 0, ack_out = 0 and sr = 0.
REQ-025 i2c_al SHALL be a registered copy of core_al (1 cycle latency).
REQ-026 When both read and write are asserted, read SHALL take priority. stop with neither read nor write SHALL issue STOP only.

Reset
REQ-027 nReset low SHALL asynchronously force:
  - state IDLE, core_cmd = NOP, core_txd = 0;
  - cmd_ack = 0, ack_out = 0, i2c_al = 0;
  - sr = 0 (dout = 8'h00), bcnt = 0.
REQ-028 rst = 1 SHALL apply the same values synchronously from any state. A reset mid-byte SHALL abandon the transfer with no cmd_ack.

Verification
REQ-029 SHALL cover: start=1, write=1, din=8'hA5, bit-controller model ACKs each command, slave ACK 0. Required response: core_cmd sequence START, WRITE×8 with core_txd 1,0,1,0,0,1,0,1, then READ. ack_out = 0, with a single cmd_ack pulse.
REQ-030 SHALL cover: read=1, ack_in=1, stop=1, model returns bits 0x3C. Required response: READ×8, then WRITE with core_txd = 1, then STOP. dout = 8'h3C, with one cmd_ack after the STOP ack.
REQ-031 SHALL cover: stop=1 alone. Required response: core_cmd = STOP, then NOP after core_ack, with cmd_ack pulsed once.
REQ-032 SHALL cover: core_al = 1 at the 4th WRITE bit. Required response: next cycle IDLE, core_cmd = NOP, i2c_al = 1, no cmd_ack.
REQ-033 SHALL cover: nReset low mid-READ (bcnt = 3). Required response: immediately core_cmd = NOP and dout = 8'h00. After release, a new write=1 with din=8'hFF completes normally.
REQ-034 SHALL cover: write held high across cmd_ack. Required response: no command is issued in the cmd_ack cycle, and a second byte starts on the following cycle.
